// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : piso_pkg
//  Description : Shared types and helpers for the piso_ser serializer:
//                the two-state shifter FSM encoding and the bit-index
//                counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package piso_pkg;

    // Shifter FSM: IDLE waits for a held word, SHIFT walks the frame bits.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_e;

    // Width of a counter that indexes bits 0..width-1 (never below 1 bit).
    function automatic int piso_cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/piso_hold_buf.sv
`default_nettype none
// ============================================================================
//  Module      : piso_hold_buf
//  Description : One-entry holding register with valid/ready input handshake.
//                Stores one word plus its bit-order flag until the shifter
//                takes it.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                flush_i         - discard the held word (wins over accept)
//                in_valid_i      - upstream offers in_data_i
//                in_ready_o      - entry free and not in reset (combinational)
//                in_data_i       - {bit order, word}, DW bits
//                take_i          - shifter consumes the held entry this edge
//                hold_data_o     - held {bit order, word}
//                hold_full_o     - entry occupied
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_hold_buf #(
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    input  logic          take_i,
    output logic [DW-1:0] hold_data_o,
    output logic          hold_full_o
);

    logic          full_q;
    logic [DW-1:0] data_q;
    logic          accept_w;

    assign in_ready_o  = !full_q && !rst;
    assign accept_w    = in_valid_i && in_ready_o;
    assign hold_data_o = data_q;
    assign hold_full_o = full_q;

    // Accept and take are mutually exclusive: take only happens while full,
    // and in_ready is low while full.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (flush_i) begin
            full_q <= 1'b0;
        end else if (accept_w) begin
            data_q <= in_data_i;
            full_q <= 1'b1;
        end else if (take_i) begin
            full_q <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/piso_ser.sv
`default_nettype none
// ============================================================================
//  Module      : piso_ser
//  Description : Parallel-in serial-out serializer with per-word bit order,
//                a one-entry holding register for gapless back-to-back
//                frames, a shift-enable (baud tick) input and flush.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                in_valid/ready  - word handshake
//                in_data         - parallel word, WIDTH bits
//                in_msb_first    - 1 = MSB first, 0 = LSB first (per word)
//                ser_en          - shifter advances only when high
//                flush           - abort held and shifting words
//                ser_out         - registered serial bit
//                ser_valid       - ser_out carries a frame bit
//                frame_start/end - ser_out is first / last bit of a frame
//                busy            - word held or shifting
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_ser
    import piso_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = piso_cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_msb_first,
    input  logic             ser_en,
    input  logic             flush,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] PEN_IDX  = CNT_W'(WIDTH - 2);

    // ------------------------------------------------------------------
    // Holding register
    // ------------------------------------------------------------------
    logic [WIDTH:0]   hold_data_w;
    logic             hold_full_w;
    logic             take_w;
    logic [WIDTH-1:0] hold_word_w;
    logic             hold_msb_w;

    piso_hold_buf #(
        .DW (WIDTH + 1)
    ) u_hold (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   ({in_msb_first, in_data}),
        .take_i      (take_w),
        .hold_data_o (hold_data_w),
        .hold_full_o (hold_full_w)
    );

    assign hold_word_w = hold_data_w[WIDTH-1:0];
    assign hold_msb_w  = hold_data_w[WIDTH];

    // ------------------------------------------------------------------
    // Shifter state
    // ------------------------------------------------------------------
    piso_state_e      state_q, state_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             msb_q, msb_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             fstart_q, fstart_d;
    logic             fend_q, fend_d;

    logic at_last_w;
    logic transfer_w;

    assign at_last_w  = (state_q == SHIFT) && (idx_q == LAST_IDX);
    // A transfer starts a frame from IDLE, or chains onto the last bit of
    // the current frame so back-to-back words leave no gap.
    assign transfer_w = ser_en && hold_full_w &&
                        ((state_q == IDLE) || at_last_w);
    assign take_w     = transfer_w && !flush;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            shreg_q     <= '0;
            msb_q       <= 1'b0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            fstart_q    <= 1'b0;
            fend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            msb_q       <= msb_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            fstart_q    <= fstart_d;
            fend_q      <= fend_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else if (ser_en) begin
            case (state_q)
                IDLE:    if (hold_full_w) state_d = SHIFT;
                SHIFT:   if (at_last_w && !hold_full_w) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath / registered-output next values
    always_comb begin
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        msb_d       = msb_q;
        ser_out_d   = ser_out_q;
        ser_valid_d = ser_valid_q;
        fstart_d    = fstart_q;
        fend_d      = fend_q;

        if (flush) begin
            idx_d       = '0;
            ser_out_d   = 1'b0;
            ser_valid_d = 1'b0;
            fstart_d    = 1'b0;
            fend_d      = 1'b0;
        end else if (transfer_w) begin
            // The first bit goes straight to ser_out; the shifter keeps the
            // remainder pre-shifted so the next bit is always at its edge.
            msb_d       = hold_msb_w;
            idx_d       = '0;
            ser_out_d   = hold_msb_w ? hold_word_w[WIDTH-1] : hold_word_w[0];
            shreg_d     = hold_msb_w ? (hold_word_w << 1) : (hold_word_w >> 1);
            ser_valid_d = 1'b1;
            fstart_d    = 1'b1;
            fend_d      = 1'b0;
        end else if (ser_en && (state_q == SHIFT)) begin
            if (!at_last_w) begin
                idx_d       = idx_q + 1'b1;
                ser_out_d   = msb_q ? shreg_q[WIDTH-1] : shreg_q[0];
                shreg_d     = msb_q ? (shreg_q << 1) : (shreg_q >> 1);
                fstart_d    = 1'b0;
                fend_d      = (idx_q == PEN_IDX);
            end else begin
                idx_d       = '0;
                ser_out_d   = 1'b0;
                ser_valid_d = 1'b0;
                fstart_d    = 1'b0;
                fend_d      = 1'b0;
            end
        end
    end

    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign frame_start = fstart_q;
    assign frame_end   = fend_q;
    assign busy        = hold_full_w || (state_q == SHIFT);

endmodule
`default_nettype wire
